// File: rtl/serial_pkg.sv
// Shared types for the serial word loader: framing FSM state encoding.
package serial_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLoad  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_word_loader.sv
// Serial-to-parallel front end: assembles WIDTH strobed bits after a start and emits a
// one-cycle load pulse with the completed word; reports strobes that arrive outside a frame.
module serial_word_loader
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             abort,
  output logic             busy,
  output logic             load,
  output logic [WIDTH-1:0] word,
  output logic             dropped
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, load_q, dropped_q;

  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) begin
      sr_d = {sr_q[WIDTH-2:0], bit_in};
    end else begin
      sr_d = {bit_in, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      dropped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A strobe coinciding with start is still outside the frame.
          dropped_q <= bit_valid;
          if (start) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (bit_valid) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
              word_q  <= sr_d;
              load_q  <= 1'b1;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          dropped_q <= bit_valid;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign load    = load_q;
  assign word    = word_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench: an MSB-first and an LSB-first loader share one stimulus stream;
// the MSB-first instance also feeds a downstream load-enabled register.
module tb_serial_word_loader;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset, start, bit_valid, bit_in, abort;
  logic         busy_m, load_m, dropped_m;
  logic         busy_l, load_l, dropped_l;
  logic [W-1:0] word_m, word_l, q_m;

  int n_vec = 0;
  int n_err = 0;
  int n_load_m = 0;
  int n_load_l = 0;
  int n_drop_m = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .abort     (abort),
    .busy      (busy_m),
    .load      (load_m),
    .word      (word_m),
    .dropped   (dropped_m)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .abort     (abort),
    .busy      (busy_l),
    .load      (load_l),
    .word      (word_l),
    .dropped   (dropped_l)
  );

  // Downstream Register stage
  always_ff @(posedge clk) begin
    if (reset) q_m <= '0;
    else if (load_m) q_m <= word_m;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (load_m) n_load_m = n_load_m + 1;
    if (load_l) n_load_l = n_load_l + 1;
    if (dropped_m) n_drop_m = n_drop_m + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends 16 bits; returns just after the edge that samples the last bit.
  task automatic send_word(input logic [15:0] val, input bit msb, input int gap_at,
                           input int gap_len);
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      bit_in    = msb ? val[15-i] : val[i];
      tick();
      bit_valid = 1'b0;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) tick();
      end
    end
  endtask

  int ld0, dr0, t1, t2;

  initial begin
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_busy", busy_m, 0);
    check_eq("reset_load", load_m, 0);
    check_eq("reset_word", word_m, 0);
    check_eq("reset_dropped", dropped_m, 0);

    // MSB-first frame
    ld0 = n_load_m;
    start_frame();
    check_eq("start_busy", busy_m, 1);
    send_word(16'hA5C3, 1'b1, -1, 0);
    check_eq("msb_load", load_m, 1);
    check_eq("msb_word", word_m, 16'hA5C3);
    check_eq("msb_busy_in_load", busy_m, 1);
    tick();
    check_eq("msb_load_drop", load_m, 0);
    check_eq("msb_busy_drop", busy_m, 0);
    check_eq("msb_q", q_m, 16'hA5C3);
    check_eq("msb_load_count", n_load_m - ld0, 1);

    // LSB-first with a 3-cycle gap after bit 7
    ld0 = n_load_l;
    start_frame();
    send_word(16'h1234, 1'b0, 7, 3);
    check_eq("lsb_load", load_l, 1);
    check_eq("lsb_word", word_l, 16'h1234);
    check_eq("lsb_on_msb_word", word_m, 16'h2C48);
    tick();
    check_eq("lsb_load_count", n_load_l - ld0, 1);

    // Abort mid-frame
    start_frame();
    send_word(16'hFFFF, 1'b1, -1, 0);
    check_eq("ffff_word", word_m, 16'hFFFF);
    tick();
    ld0 = n_load_m;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check_eq("abort_busy", busy_m, 0);
    check_eq("abort_load", load_m, 0);
    check_eq("abort_word", word_m, 16'hFFFF);
    check_eq("abort_dropped", dropped_m, 0);
    tick();
    check_eq("abort_no_load", n_load_m - ld0, 0);
    start_frame();
    send_word(16'h0001, 1'b1, -1, 0);
    check_eq("after_abort_word", word_m, 16'h0001);
    tick();

    // Dropped strobes in IDLE and in LOAD
    dr0 = n_drop_m;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    check_eq("drop_idle", dropped_m, 1);
    check_eq("drop_idle_busy", busy_m, 0);
    tick();
    check_eq("drop_idle_end", dropped_m, 0);
    start_frame();
    send_word(16'h3C5A, 1'b1, -1, 0);
    bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    check_eq("drop_load", dropped_m, 1);
    check_eq("drop_load_word", word_m, 16'h3C5A);
    tick();
    check_eq("drop_load_end", dropped_m, 0);
    check_eq("drop_count", n_drop_m - dr0, 2);

    // Reset mid-frame
    ld0 = n_load_m;
    start_frame();
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; bit_in = i[0];
      tick();
    end
    bit_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_busy", busy_m, 0);
    check_eq("rst_word", word_m, 0);
    check_eq("rst_load", load_m, 0);
    check_eq("rst_q", q_m, 0);
    start_frame();
    check_eq("rst_restart_busy", busy_m, 1);
    check_eq("rst_no_load", n_load_m - ld0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Back-to-back frames
    start_frame();
    send_word(16'h0F0F, 1'b1, -1, 0);
    t1 = cyc;
    check_eq("b2b_load1", load_m, 1);
    check_eq("b2b_word1", word_m, 16'h0F0F);
    tick();
    start_frame();
    check_eq("b2b_busy2", busy_m, 1);
    send_word(16'hF0F0, 1'b1, -1, 0);
    t2 = cyc;
    check_eq("b2b_load2", load_m, 1);
    check_eq("b2b_word2", word_m, 16'hF0F0);
    check_eq("b2b_spacing", t2 - t1, W + 2);
    tick();
    check_eq("b2b_q", q_m, 16'hF0F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
